// File: rtl/modexp_sequencer.sv
// Modular exponentiation sequencer: walks a single combinational modular multiplier through a
// right-to-left square-and-multiply schedule and hands back base^exponent mod modulus.
module modexp_sequencer #(
    parameter int unsigned WIDTH     = 32,
    parameter logic [3:0]  OP_MODMUL = 4'b0010
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [WIDTH-1:0] alu_m,
    input  logic [WIDTH-1:0] alu_r
);

    typedef enum logic [2:0] {StIdle, StInit, StMul, StSqr, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] e_q, e_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;

    // Step chosen once the exponent has been (re)computed: finish, multiply in, or square again.
    function automatic state_e step_after(input logic [WIDTH-1:0] e);
        if (e == '0) begin
            return StDone;
        end else if (e[0]) begin
            return StMul;
        end else begin
            return StSqr;
        end
    endfunction

    // State and datapath registers, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            b_q      <= '0;
            e_q      <= '0;
            m_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            b_q      <= b_d;
            e_q      <= e_d;
            m_q      <= m_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    // Next-state, ALU drive and datapath updates for the current schedule step.
    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        e_d     = e_q;
        m_d     = m_q;
        acc_d   = acc_q;
        busy    = 1'b0;
        done    = 1'b0;
        alu_op  = '0;
        alu_a   = '0;
        alu_b   = '0;
        alu_m   = '0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    b_d     = base;
                    e_d     = exponent;
                    m_d     = modulus;
                    state_d = (modulus == '0) ? StDone : StInit;
                end
            end
            StInit: begin
                busy    = 1'b1;
                alu_op  = OP_MODMUL;
                alu_a   = b_q;
                alu_b   = WIDTH'(1);
                alu_m   = m_q;
                // Multiplying by one reduces the base below the modulus.
                b_d     = alu_r;
                acc_d   = (m_q == WIDTH'(1)) ? '0 : WIDTH'(1);
                state_d = step_after(e_q);
            end
            StMul: begin
                busy    = 1'b1;
                alu_op  = OP_MODMUL;
                alu_a   = acc_q;
                alu_b   = b_q;
                alu_m   = m_q;
                acc_d   = alu_r;
                state_d = StSqr;
            end
            StSqr: begin
                busy    = 1'b1;
                alu_op  = OP_MODMUL;
                alu_a   = b_q;
                alu_b   = b_q;
                alu_m   = m_q;
                b_d     = alu_r;
                e_d     = e_q >> 1;
                state_d = step_after(e_d);
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Result and error are captured on the edge into DONE so they are valid alongside done.
    always_comb begin
        result_d = result_q;
        err_d    = err_q;
        if (state_q != StDone && state_d == StDone) begin
            err_d    = (m_d == '0);
            result_d = err_d ? '0 : acc_d;
        end
    end

    assign result = result_q;
    assign err    = err_q;

endmodule

// File: doc/modexp_sequencer.md
# modexp_sequencer

Sequencer that computes modular exponentiation, base^exponent mod modulus, by stepping a single combinational `modular_alu_ext` through a right-to-left square-and-multiply schedule. It sits between a requester using a start/done handshake and one `modular_alu_ext` instance. It owns that ALU's `op`/`A`/`B`/`M` inputs and reads back `R` in the same cycle.

## Interface
- `WIDTH`, 32: operand, modulus, exponent and result width; must match the ALU's `WIDTH`.
- `OP_MODMUL`, 4'b0010: ALU op code for (A*B) mod M; the ALU must return a correct result for any A, B < 2^WIDTH, M ≥ 1.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request pulse; sampled only in IDLE.
- `base` in WIDTH: base, latched on accepted start.
- `exponent` in WIDTH: exponent, latched on accepted start.
- `modulus` in WIDTH: modulus, latched on accepted start.
- `busy` out 1: high in INIT, MUL and SQR.
- `done` out 1: one-cycle pulse; `result` and `err` are valid in that cycle.
- `err` out 1: set with `done` when modulus == 0.
- `result` out WIDTH: final value, held until the next accepted start or reset.
- `alu_op` out 4: drives ALU `op`.
- `alu_a` out WIDTH: drives ALU `A`.
- `alu_b` out WIDTH: drives ALU `B`.
- `alu_m` out WIDTH: drives ALU `M`.
- `alu_r` in WIDTH: ALU `R`, combinational from the `alu_*` outputs.

## Operation
- Internal registers: `b_r` (running base), `e_r` (remaining exponent), `m_r`, `acc`.
- States: IDLE, INIT, MUL, SQR, DONE.
- **IDLE**
  - On `start`, latch the inputs into `b_r`, `e_r`, `m_r`.
  - If modulus == 0, go to DONE with err pending.
  - Otherwise go to INIT.
- **INIT**
  - ALU is driven with a=`b_r`, b=1.
  - `b_r` ← `alu_r`, which reduces the base mod M.
  - `acc` ← (m_r == 1) ? 0 : 1.
- **MUL**
  - ALU is driven with a=`acc`, b=`b_r`.
  - `acc` ← `alu_r`.
  - Next state is always SQR.
- **SQR**
  - ALU is driven with a=`b_r`, b=`b_r`.
  - `b_r` ← `alu_r`.
  - `e_r` ← `e_r` >> 1.
- **Decision after INIT or SQR**, evaluated on the updated `e_r`:
  - `e_r` == 0 → DONE.
  - `e_r`[0] == 1 → MUL.
  - Otherwise → SQR.
- **DONE**
  - `done` = 1 for one cycle.
  - `result` ← `acc`, or 0 when err.
  - `err` = 1 only for the modulus == 0 case.
  - Next state is IDLE.
- **ALU drive**
  - `alu_m` = `m_r` in INIT, MUL and SQR.
  - `alu_op` = `OP_MODMUL` in INIT, MUL and SQR.
  - In IDLE and DONE, all `alu_*` outputs are 0.
- **Width rules**
  - All values are WIDTH bits; no widening is done here. The ALU handles the 2·WIDTH product internally.
  - `acc` and `b_r` are always < M after INIT.
- `start` while not in IDLE is ignored, with no queuing.

## Timing
- **Latency:** `start` is sampled at edge k.
  - INIT in cycle k+1, then one cycle per MUL/SQR step.
  - `done` is high in cycle k+2+popcount(E)+bitlen(E). bitlen(0)=0.
  - E = 0: `done` at k+2.
  - modulus == 0: `done` at k+1.
- Worst case is E = 2^WIDTH−1: `done` at k+2+2·WIDTH.
- **Reset values:** state IDLE; `busy`=0, `done`=0, `err`=0, `result`=0; all `alu_*`=0; all internal registers 0.
- **Reset mid-operation:** at the next edge return to IDLE with reset values. No `done` is produced for the aborted request.
- `start` asserted in the DONE cycle is ignored. `start` in the first IDLE cycle after DONE is accepted.
- `result` and `err` change only at the DONE transition and on reset.

## Test plan
- base=4, exponent=13, modulus=497, `start` at edge k → `done` in cycle k+9, `result`=445, `err`=0; `busy` high in cycles k+1..k+8.
- base=3, exponent=200, modulus=13 → `done` at k+13, `result`=9.
- base=100, exponent=0, modulus=13 → `done` at k+2, `result`=1; same request with modulus=1 → `result`=0.
- modulus=0 (base=5, exponent=3) → `done` at k+1, `err`=1, `result`=0; the next valid request clears `err`.
- base=45, exponent=0x80000000, modulus=97 → `done` at k+35, `result` equal to the software modexp model. A second `start` pulsed mid-run is ignored, and exactly one `done` is produced.
- `rst` asserted in cycle k+4 of the base=4/exp=13/M=497 run → all outputs 0 next cycle, no `done`; a fresh request afterwards returns 445 at +9.
